// File: rtl/sru_cmd_pkg.sv
// sru_cmd_pkg
//   Shared definitions for the SRU register-command path: command/timer
//   widths, the read flag position in the address word, the arbiter state
//   encoding and a helper that sizes requester index fields.
package sru_cmd_pkg;

  localparam int CMD_W  = 32;  // command address/data width
  localparam int RD_BIT = 31;  // address bit that marks a read
  localparam int TMR_W  = 16;  // wait/gap timer and timeout counter width

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    RELEASE,
    GAPW
  } state_e;

  // Index width for n requesters; a single requester still gets one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sru_rr_arbiter.sv
// sru_rr_arbiter
//   Combinational round-robin pick: the first asserted request found when
//   searching upward from ptr, wrapping past NREQ-1 back to 0.
// Ports
//   req        in   NREQ    request vector
//   ptr        in   IDX_W   index with highest priority this round
//   win_gnt    out  NREQ    one-hot winner (all zero when no request)
//   win_idx    out  IDX_W   winner index (0 when no request)
//   win_valid  out  1       at least one request asserted
module sru_rr_arbiter
  import sru_cmd_pkg::*;
#(
  parameter int NREQ = 2,
  localparam int IDX_W = idx_w(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  win_gnt,
  output logic [IDX_W-1:0] win_idx,
  output logic             win_valid
);

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  logic [IDX_W-1:0]  off;
  logic [IDX_W:0]    sum;

  // Rotating a doubled copy puts request[ptr] at bit 0, so a plain
  // lowest-bit-first search implements the wrap-around order.
  assign dbl = {req, req} >> ptr;
  assign rot = dbl[NREQ-1:0];

  always_comb begin
    off       = '0;
    win_valid = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k[IDX_W-1:0]]) begin
        off       = k[IDX_W-1:0];
        win_valid = 1'b1;
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (IDX_W + 1)'(NREQ)) begin
      sum = sum - (IDX_W + 1)'(NREQ);
    end
    win_idx = sum[IDX_W-1:0];
  end

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_gnt
    assign win_gnt[gi] = win_valid && (win_idx == IDX_W'(gi));
  end

endmodule

// File: rtl/sru_cmd_arbiter.sv
// sru_cmd_arbiter
//   Shares the single SRU register-command port between NREQ sources with a
//   round-robin grant and one command in flight. Writes complete on ack or
//   after WR_HOLD cycles; reads complete on ack or time out after RD_TIMEOUT
//   cycles. A forced GAP of idle cycles separates consecutive commands.
// Ports
//   gclk_40m        in   clock
//   reset           in   synchronous, active-high
//   req_dv          in   per-source command valid (level)
//   req_addr        in   per-source address, bit 31 = read
//   req_data        in   per-source write data
//   req_grant       out  one-hot grant, latch through end of RELEASE
//   req_done        out  one-cycle completion pulse to the granted source
//   req_tout        out  qualifies req_done: read timed out
//   m_cmd_dv        out  command valid to executor
//   m_cmd_addr      out  latched command address
//   m_cmd_data      out  latched command data
//   m_reply_stored  in   executor ack
//   busy            out  high whenever the FSM is not IDLE
//   tout_cnt        out  saturating read-timeout count
module sru_cmd_arbiter
  import sru_cmd_pkg::*;
#(
  parameter int NREQ       = 2,
  parameter int RD_TIMEOUT = 250,
  parameter int WR_HOLD    = 8,
  parameter int GAP        = 4
) (
  input  logic                  gclk_40m,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_dv,
  input  logic [CMD_W*NREQ-1:0] req_addr,
  input  logic [CMD_W*NREQ-1:0] req_data,
  output logic [NREQ-1:0]       req_grant,
  output logic [NREQ-1:0]       req_done,
  output logic                  req_tout,
  output logic                  m_cmd_dv,
  output logic [CMD_W-1:0]      m_cmd_addr,
  output logic [CMD_W-1:0]      m_cmd_data,
  input  logic                  m_reply_stored,
  output logic                  busy,
  output logic [TMR_W-1:0]      tout_cnt
);

  localparam int IDX_W = idx_w(NREQ);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic              tout_q, tout_d;
  logic              cmd_dv_q, cmd_dv_d;
  logic [CMD_W-1:0]  addr_q, addr_d;
  logic [CMD_W-1:0]  data_q, data_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [TMR_W-1:0]  tout_cnt_q, tout_cnt_d;

  logic [NREQ-1:0]   arb_gnt;
  logic [IDX_W-1:0]  arb_idx;
  logic              arb_valid;
  logic [CMD_W-1:0]  addr_arr [NREQ];
  logic [CMD_W-1:0]  data_arr [NREQ];
  logic              is_read, wr_lim, rd_lim;

  sru_rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req       (req_dv),
    .ptr       (ptr_q),
    .win_gnt   (arb_gnt),
    .win_idx   (arb_idx),
    .win_valid (arb_valid)
  );

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign addr_arr[gi] = req_addr[gi*CMD_W +: CMD_W];
    assign data_arr[gi] = req_data[gi*CMD_W +: CMD_W];
  end

  // Command type comes from the latched address so a source dropping its
  // request mid-command cannot change how the command completes.
  assign is_read = addr_q[RD_BIT];
  assign wr_lim  = !is_read && (timer_q == TMR_W'(WR_HOLD - 1));
  assign rd_lim  =  is_read && (timer_q == TMR_W'(RD_TIMEOUT - 1));

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    done_d     = '0;
    tout_d     = 1'b0;
    cmd_dv_d   = cmd_dv_q;
    addr_d     = addr_q;
    data_d     = data_q;
    timer_d    = timer_q;
    tout_cnt_d = tout_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          grant_d = arb_gnt;
          addr_d  = addr_arr[arb_idx];
          data_d  = data_arr[arb_idx];
          ptr_d   = (arb_idx == IDX_W'(NREQ - 1)) ? '0 : arb_idx + IDX_W'(1);
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cmd_dv_d = 1'b1;
        timer_d  = '0;
        state_d  = WAIT;
      end
      WAIT: begin
        timer_d = timer_q + TMR_W'(1);
        if (m_reply_stored || wr_lim || rd_lim) begin
          cmd_dv_d = 1'b0;
          done_d   = grant_q;
          timer_d  = '0;
          state_d  = RELEASE;
          // An ack in the same cycle as the read limit counts as a reply.
          if (!m_reply_stored && rd_lim) begin
            tout_d = 1'b1;
            if (tout_cnt_q != '1) begin
              tout_cnt_d = tout_cnt_q + TMR_W'(1);
            end
          end
        end
      end
      RELEASE: begin
        // Wait for the executor to drop its ack so a held ack is not taken
        // as the reply to the next command; a stuck ack is overridden.
        timer_d = timer_q + TMR_W'(1);
        if (!m_reply_stored || (timer_q == TMR_W'(RD_TIMEOUT - 1))) begin
          grant_d = '0;
          timer_d = '0;
          state_d = GAPW;
        end
      end
      GAPW: begin
        timer_d = timer_q + TMR_W'(1);
        if (timer_q == TMR_W'(GAP - 1)) begin
          timer_d = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge gclk_40m) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      grant_q    <= '0;
      done_q     <= '0;
      tout_q     <= 1'b0;
      cmd_dv_q   <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      timer_q    <= '0;
      tout_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      done_q     <= done_d;
      tout_q     <= tout_d;
      cmd_dv_q   <= cmd_dv_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      timer_q    <= timer_d;
      tout_cnt_q <= tout_cnt_d;
    end
  end

  assign req_grant  = grant_q;
  assign req_done   = done_q;
  assign req_tout   = tout_q;
  assign m_cmd_dv   = cmd_dv_q;
  assign m_cmd_addr = addr_q;
  assign m_cmd_data = data_q;
  assign busy       = (state_q != IDLE);
  assign tout_cnt   = tout_cnt_q;

endmodule

// File: tb/tb_sru_cmd_arbiter.sv
// tb_sru_cmd_arbiter
//   Directed bench for sru_cmd_arbiter (NREQ=2, default timing). A per-cycle
//   vector table covers a plain write and an acked read with a held ack;
//   hand-written sequences cover timeout, round-robin order, reset
//   mid-command and a request dropped after grant.
module tb_sru_cmd_arbiter;

  logic        gclk_40m = 1'b0;
  logic        reset;
  logic [1:0]  req_dv;
  logic [63:0] req_addr;
  logic [63:0] req_data;
  logic [1:0]  req_grant;
  logic [1:0]  req_done;
  logic        req_tout;
  logic        m_cmd_dv;
  logic [31:0] m_cmd_addr;
  logic [31:0] m_cmd_data;
  logic        m_reply_stored;
  logic        busy;
  logic [15:0] tout_cnt;

  int n_pass  = 0;
  int n_total = 0;

  always #5 gclk_40m = ~gclk_40m;

  sru_cmd_arbiter #(.NREQ(2), .RD_TIMEOUT(250), .WR_HOLD(8), .GAP(4)) dut (
    .gclk_40m       (gclk_40m),
    .reset          (reset),
    .req_dv         (req_dv),
    .req_addr       (req_addr),
    .req_data       (req_data),
    .req_grant      (req_grant),
    .req_done       (req_done),
    .req_tout       (req_tout),
    .m_cmd_dv       (m_cmd_dv),
    .m_cmd_addr     (m_cmd_addr),
    .m_cmd_data     (m_cmd_data),
    .m_reply_stored (m_reply_stored),
    .busy           (busy),
    .tout_cnt       (tout_cnt)
  );

  typedef struct {
    int          n;      // cycles this row lasts
    logic [1:0]  dv;     // req_dv driven
    logic        ack;    // m_reply_stored driven
    logic [1:0]  grant;  // expected outputs during those cycles
    logic        cmd_dv;
    logic [1:0]  done;
    logic        tout;
    logic        bsy;
    logic [31:0] addr;
    logic [31:0] data;
  } vec_t;

  localparam int NV = 15;
  vec_t tbl [NV];

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 unit after the edge.
  task automatic step();
    @(posedge gclk_40m);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (busy && k < 40) begin step(); k++; end
    chk(name, {79'd0, busy}, 80'd0);
  endtask

  initial begin
    int k;
    int cnt;
    int bad;
    logic [1:0] order [4];

    // Test 1: write src0, no ack. Test 2: read src1, ack on WAIT cycle 20, held 5 more.
    tbl[0]  = '{1,  2'b01, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0};
    tbl[1]  = '{1,  2'b01, 1'b0, 2'b01, 1'b0, 2'b00, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF};
    tbl[2]  = '{8,  2'b01, 1'b0, 2'b01, 1'b1, 2'b00, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF};
    tbl[3]  = '{1,  2'b00, 1'b0, 2'b01, 1'b0, 2'b01, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF};
    tbl[4]  = '{4,  2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF};
    tbl[5]  = '{1,  2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 32'h10, 32'hDEADBEEF};
    tbl[6]  = '{1,  2'b10, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 32'h10, 32'hDEADBEEF};
    tbl[7]  = '{1,  2'b10, 1'b0, 2'b10, 1'b0, 2'b00, 1'b0, 1'b1, 32'h80000004, 32'h12345678};
    tbl[8]  = '{19, 2'b10, 1'b0, 2'b10, 1'b1, 2'b00, 1'b0, 1'b1, 32'h80000004, 32'h12345678};
    tbl[9]  = '{1,  2'b10, 1'b1, 2'b10, 1'b1, 2'b00, 1'b0, 1'b1, 32'h80000004, 32'h12345678};
    tbl[10] = '{1,  2'b00, 1'b1, 2'b10, 1'b0, 2'b10, 1'b0, 1'b1, 32'h80000004, 32'h12345678};
    tbl[11] = '{4,  2'b00, 1'b1, 2'b10, 1'b0, 2'b00, 1'b0, 1'b1, 32'h80000004, 32'h12345678};
    tbl[12] = '{1,  2'b00, 1'b0, 2'b10, 1'b0, 2'b00, 1'b0, 1'b1, 32'h80000004, 32'h12345678};
    tbl[13] = '{4,  2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 32'h80000004, 32'h12345678};
    tbl[14] = '{1,  2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 32'h80000004, 32'h12345678};

    reset          = 1'b1;
    req_dv         = 2'b00;
    req_addr       = {32'h8000_0004, 32'h0000_0010};
    req_data       = {32'h1234_5678, 32'hDEAD_BEEF};
    m_reply_stored = 1'b0;
    repeat (3) step();
    reset = 1'b0;

    chk("reset_outputs",
        {7'd0, req_grant, req_done, req_tout, m_cmd_dv, busy, tout_cnt, m_cmd_addr, m_cmd_data},
        80'd0);

    // Vector table, one comparison per cycle.
    for (int r = 0; r < NV; r++) begin
      for (int j = 0; j < tbl[r].n; j++) begin
        req_dv         = tbl[r].dv;
        m_reply_stored = tbl[r].ack;
        chk($sformatf("vec%0d.%0d", r, j),
            {9'd0, req_grant, m_cmd_dv, req_done, req_tout, busy, m_cmd_addr, m_cmd_data},
            {9'd0, tbl[r].grant, tbl[r].cmd_dv, tbl[r].done, tbl[r].tout, tbl[r].bsy,
             tbl[r].addr, tbl[r].data});
        step();
      end
    end
    chk("t2_tout_cnt", {64'd0, tout_cnt}, 80'd0);

    // Test 3: read from src1 with no ack times out after 250 WAIT cycles.
    req_dv = 2'b10;
    k = 0;
    while (!m_cmd_dv && k < 20) begin step(); k++; end
    cnt = 0;
    while (m_cmd_dv && cnt < 400) begin step(); cnt++; end
    chk("t3_dv_cycles", 80'(cnt), 80'd250);
    chk("t3_done", {78'd0, req_done}, 80'b10);
    chk("t3_tout", {79'd0, req_tout}, 80'd1);
    chk("t3_tout_cnt", {64'd0, tout_cnt}, 80'd1);
    req_dv = 2'b00;
    step();
    chk("t3_tout_pulse", {79'd0, req_tout}, 80'd0);
    wait_idle("t3_idle");

    // Test 4: both sources request together and keep requesting.
    req_addr[63:32] = 32'h0000_0020;
    req_dv = 2'b11;
    order[0] = 2'b01; order[1] = 2'b10; order[2] = 2'b01; order[3] = 2'b10;
    for (int i = 0; i < 4; i++) begin
      k = 0;
      while (req_done == 2'b00 && k < 100) begin step(); k++; end
      chk($sformatf("t4_order%0d", i), {78'd0, req_done}, {78'd0, order[i]});
      step();
    end
    req_dv = 2'b00;
    wait_idle("t4_idle");

    // Test 5: reset during WAIT.
    req_dv = 2'b01;
    k = 0;
    while (!m_cmd_dv && k < 20) begin step(); k++; end
    step();
    step();
    reset  = 1'b1;
    req_dv = 2'b00;
    step();
    chk("t5_after_reset",
        {7'd0, req_grant, req_done, req_tout, m_cmd_dv, busy, tout_cnt, m_cmd_addr, m_cmd_data},
        80'd0);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      if (req_done != 2'b00 || m_cmd_dv) bad++;
      step();
    end
    chk("t5_no_done", 80'(bad), 80'd0);

    // Test 6: request dropped one cycle after grant still completes.
    req_dv = 2'b01;
    k = 0;
    while (req_grant == 2'b00 && k < 20) begin step(); k++; end
    step();
    req_dv = 2'b00;
    k = 0;
    while (req_done == 2'b00 && k < 50) begin step(); k++; end
    chk("t6_done", {78'd0, req_done}, 80'b01);
    chk("t6_tout", {79'd0, req_tout}, 80'd0);
    chk("t6_addr", {48'd0, m_cmd_addr}, {48'd0, 32'h10});
    wait_idle("t6_idle");
    chk("t6_addr_hold", {16'd0, m_cmd_addr, m_cmd_data}, {16'd0, 32'h10, 32'hDEADBEEF});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Absolute time limit so the run always reaches its summary.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, %0d/%0d passed so far", n_pass, n_total);
    $fatal(1);
  end

endmodule
